// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among four byte requesters.
// Define UART_ARB_TIMEOUT_EN to build the launch-to-done watchdog driving o_timeout.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned GAP_CYCLES     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [8*NUM_REQ-1:0]   i_data,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic                   o_tx_start,
    output logic [7:0]             o_tx_byte,
    input  logic                   i_tx_done,
    output logic                   o_busy,
    output logic                   o_timeout
);

    localparam bit          HAS_GAP  = (GAP_CYCLES != 0);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    if (NUM_REQ != 4 || GAP_CYCLES > 65535 || TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535)
    begin : g_param_check
        $error("uart_tx_arbiter: unsupported parameter value");
    end

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;

    state_t               state, state_nx;
    logic [1:0]           ptr, ptr_nx;
    logic [1:0]           win;
    logic                 win_vld;
    logic [7:0]           byte_nx;
    logic [NUM_REQ-1:0]   grant_nx;
    logic                 start_nx;
    logic [15:0]          gap_cnt, gap_nx;

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_cnt, wd_nx;
    logic        timeout_nx;
`endif

    // Search starts one past the last winner, so the last winner is checked last.
    always_comb begin
        win     = ptr;
        win_vld = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            if (!win_vld && i_req[ptr + 2'(i)]) begin
                win     = ptr + 2'(i);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        byte_nx  = o_tx_byte;
        grant_nx = '0;
        start_nx = 1'b0;
        gap_nx   = gap_cnt;
`ifdef UART_ARB_TIMEOUT_EN
        wd_nx      = wd_cnt;
        timeout_nx = o_timeout;
`endif
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nx      = LAUNCH;
                    ptr_nx        = win;
                    byte_nx       = i_data[8*win +: 8];
                    grant_nx[win] = 1'b1;
                    start_nx      = 1'b1;
                end
            end
            LAUNCH: begin
                state_nx = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                wd_nx = '0;
`endif
            end
            WAIT_DONE: begin
                if (i_tx_done) begin
                    state_nx = HAS_GAP ? GAP : IDLE;
                    gap_nx   = '0;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (wd_cnt == WD_LAST) begin
                    state_nx   = IDLE;
                    timeout_nx = 1'b1;
                end else begin
                    wd_nx = wd_cnt + 16'd1;
                end
`endif
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_nx = IDLE;
                else                     gap_nx   = gap_cnt + 16'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // All outputs are registered; o_busy is taken from the next state so it tracks the state exactly.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            ptr        <= 2'd3;
            o_tx_byte  <= '0;
            o_grant    <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_nx;
            ptr        <= ptr_nx;
            o_tx_byte  <= byte_nx;
            o_grant    <= grant_nx;
            o_tx_start <= start_nx;
            o_busy     <= (state_nx != IDLE);
            gap_cnt    <= gap_nx;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wd_cnt    <= '0;
            o_timeout <= 1'b0;
        end else begin
            wd_cnt    <= wd_nx;
            o_timeout <= timeout_nx;
        end
    end
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a round-robin model.
module tb_uart_tx_arbiter;

    localparam int unsigned GAP_LEN = 10;
`ifdef UART_ARB_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, done;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  grant;
    logic        start, busy, tmo;
    logic [7:0]  txb;

    logic        g_rst, g_done;
    logic [3:0]  g_req;
    logic [31:0] g_data;
    logic [3:0]  g_grant;
    logic        g_start, g_busy, g_tmo;
    logic [7:0]  g_txb;

    int checks = 0;
    int errors = 0;
    int ptr;

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(5000)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_data(data),
        .o_grant(grant), .o_tx_start(start), .o_tx_byte(txb),
        .i_tx_done(done), .o_busy(busy), .o_timeout(tmo)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(GAP_LEN), .TIMEOUT_CYCLES(100)) dut_gap (
        .i_clk(clk), .i_rst(g_rst), .i_req(g_req), .i_data(g_data),
        .o_grant(g_grant), .o_tx_start(g_start), .o_tx_byte(g_txb),
        .i_tx_done(g_done), .o_busy(g_busy), .o_timeout(g_tmo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input int p, input logic [3:0] r);
        for (int i = 1; i <= 4; i++)
            if (r[(p + i) % 4]) return (p + i) % 4;
        return -1;
    endfunction

    task automatic launch_check(input int k, input logic [7:0] b);
        tick();
        check("launch_start", start, 1);
        check("launch_grant", grant, 32'(1) << k);
        check("launch_byte", txb, b);
        check("launch_busy", busy, 1);
        ptr = k;
    endtask

    task automatic run_frame(input int n, input logic stray, input logic [7:0] b);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            done = (i == 0) ? stray : 1'b0;
            tick();
            if (start !== 1'b0 || grant !== 4'b0 || txb !== b || busy !== 1'b1) bad++;
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        check("frame_hold", bad, 0);
        check("frame_busy_after_done", busy, 0);
        check("frame_start_after_done", start, 0);
        check("frame_byte_after_done", txb, b);
    endtask

    initial begin
        logic [7:0] b0, b1;
        int         wd_busy;
        rst = 1'b1; done = 1'b0; req = '0; data = '0;
        g_rst = 1'b1; g_done = 1'b0; g_req = '0; g_data = '0;
        ptr = 3;
        tick();
        tick();
        check("rst_grant", grant, 0);
        check("rst_start", start, 0);
        check("rst_byte", txb, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", tmo, 0);
        check("rst_gap_busy", g_busy, 0);
        rst = 1'b0;
        g_rst = 1'b0;
        tick();

        repeat (2) begin
            done = 1'b1; tick(); done = 1'b0; tick();
            check("stray_idle_start", start, 0);
            check("stray_idle_busy", busy, 0);
        end

        req = 4'b0100; data[23:16] = 8'hA5;
        launch_check(2, 8'hA5);
        req = '0;
        run_frame(6, 1'b0, 8'hA5);

        req = 4'b0001; data[7:0] = 8'h3C;
        launch_check(0, 8'h3C);
        req = 4'b1000; data[31:24] = 8'hC3;
        run_frame(8, 1'b0, 8'h3C);
        launch_check(3, 8'hC3);
        req = '0;
        run_frame(3, 1'b0, 8'hC3);

        req = 4'b0001; data[7:0] = 8'($urandom);
        launch_check(0, data[7:0]);
        req = '0;
        repeat (3) tick();
        check("mid_busy", busy, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        ptr = 3;
        check("midrst_grant", grant, 0);
        check("midrst_start", start, 0);
        check("midrst_byte", txb, 0);
        check("midrst_busy", busy, 0);
        check("midrst_timeout", tmo, 0);
        done = 1'b1; tick(); done = 1'b0; tick();
        check("late_done_start", start, 0);
        check("late_done_busy", busy, 0);
        req = 4'b0011;
        b0 = 8'($urandom); b1 = 8'($urandom);
        data[7:0] = b0; data[15:8] = b1;
        launch_check(rr_pick(ptr, req), b0);
        req = 4'b0010;
        run_frame(4, 1'b0, b0);
        launch_check(1, b1);
        req = '0;
        run_frame(2, 1'b0, b1);

        rst = 1'b1; tick(); rst = 1'b0;
        ptr = 3;
        req = 4'b1111;
        data = $urandom;
        for (int f = 0; f < 5; f++) begin
            int k;
            logic [7:0] b;
            k = f % 4;
            b = data[8*k +: 8];
            launch_check(k, b);
            data[8*k +: 8] = 8'($urandom);
            run_frame(4349, 1'b0, b);
        end
        req[0] = 1'b0;

        for (int t = 0; t < 60; t++) begin
            int k, j, n;
            logic [7:0] b;
            logic stray;
            if (req == 4'b0) begin
                if ($urandom_range(0, 1) == 1) begin
                    done = 1'b1; tick(); done = 1'b0;
                    check("rnd_stray_start", start, 0);
                    check("rnd_stray_busy", busy, 0);
                end
                j = $urandom_range(0, 3);
                req[j] = 1'b1;
                data[8*j +: 8] = 8'($urandom);
            end
            k = rr_pick(ptr, req);
            b = data[8*k +: 8];
            launch_check(k, b);
            if ($urandom_range(0, 1) == 1) req[k] = 1'b0;
            else                           data[8*k +: 8] = 8'($urandom);
            for (int m = 0; m < 4; m++) begin
                if (!req[m] && $urandom_range(0, 2) == 0) begin
                    req[m] = 1'b1;
                    data[8*m +: 8] = 8'($urandom);
                end
            end
            n = $urandom_range(1, 15);
            stray = ($urandom_range(0, 3) == 0);
            run_frame(n, stray, b);
        end
        check("main_timeout_clear", tmo, 0);

        g_req = 4'b0001; g_data[7:0] = 8'h5A;
        tick();
        check("gap_launch", g_start, 1);
        check("gap_grant", g_grant, 1);
        for (int r = 0; r < 2; r++) begin
            int cnt;
            logic busy_gap, busy_idle;
            busy_gap = 1'bx;
            busy_idle = 1'bx;
            repeat (3) tick();
            g_done = 1'b1; tick(); g_done = 1'b0;
            cnt = 1;
            while (g_start !== 1'b1 && cnt < 40) begin
                g_done = (r == 1 && cnt == 5);
                tick();
                cnt++;
                if (cnt == GAP_LEN)     busy_gap  = g_busy;
                if (cnt == GAP_LEN + 1) busy_idle = g_busy;
            end
            g_done = 1'b0;
            check("gap_start_distance", cnt, GAP_LEN + 2);
            check("gap_busy_in_gap", busy_gap, 1);
            check("gap_busy_in_idle", busy_idle, 0);
            check("gap_byte", g_txb, 8'h5A);
        end

        g_req = '0;
        wd_busy = 0;
        repeat (100) begin
            tick();
            if (g_busy === 1'b1) wd_busy++;
        end
        check("wd_busy_100", wd_busy, 100);
        check("wd_timeout_early", g_tmo, 0);
        tick();
        check("wd_busy_101", g_busy, !TO_EN);
        check("wd_timeout", g_tmo, TO_EN);
        g_done = 1'b1; tick(); g_done = 1'b0;
        repeat (12) tick();
        check("wd_idle_busy", g_busy, 0);
        g_req = 4'b0001; g_data[7:0] = 8'h77;
        tick();
        check("wd_relaunch_start", g_start, 1);
        check("wd_relaunch_byte", g_txb, 8'h77);
        check("wd_sticky", g_tmo, TO_EN);
        g_req = '0;
        repeat (3) tick();
        g_done = 1'b1; tick(); g_done = 1'b0;
        check("wd_sticky_after_frame", g_tmo, TO_EN);
        g_rst = 1'b1; tick(); g_rst = 1'b0;
        check("wd_cleared_by_reset", g_tmo, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
